// File: rtl/i2s_play_seq.sv
// i2s_play_seq: playback sequencer between the SPI register wrapper and the
// I2S serializer / sample-ROM pair. It walks a programmed ROM window
// [start..end], optionally wrapping through 2^AW-1 to 0 and repeating a
// programmed number of times or forever. It tells the serializer when ROM q
// matches rom_addr, and it reports status through a small register file.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   wr_en, rd_en        one-cycle register write / read strobes
//   reg_sel[1:0]        0 CTRL/STATUS, 1 START_ADDR, 2 END_ADDR, 3 LOOP_CNT
//   data_in[7:0]        write data
//   data_out[7:0]       registered read data, held until the next read
//   word_req            serializer latched the current word (one-cycle pulse)
//   rom_addr[AW-1:0]    sample-ROM address
//   word_valid          ROM q corresponds to rom_addr
//   mute                serializer must send zeros
//   playing             sequencer is not IDLE
//   done                one-cycle pulse when playback completes normally
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | stopped, muted, rom_addr holds its last value
// S_PRIME | first address issued, waiting for ROM latency, still muted
// S_PLAY  | q valid for rom_addr, waiting for word_req
// S_FETCH | next address issued, waiting for ROM latency, unmuted

module i2s_play_seq #(
  parameter int ROM_LAT = 2,
  parameter int AW      = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [1:0]    reg_sel,
  input  logic [7:0]    data_in,
  output logic [7:0]    data_out,
  input  logic          word_req,
  output logic [AW-1:0] rom_addr,
  output logic          word_valid,
  output logic          mute,
  output logic          playing,
  output logic          done
);

  localparam int CW = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_PLAY  = 2'd2,
    S_FETCH = 2'd3
  } state_t;

  state_t state, state_nxt;

  // programmed registers
  logic [AW-1:0] start_addr_r, end_addr_r;
  logic [7:0]    loop_cnt_r;
  logic          loop_forever_r;

  // working copies, captured at start
  logic [AW-1:0] w_start, w_start_nxt;
  logic [AW-1:0] w_end, w_end_nxt;
  logic          w_forever, w_forever_nxt;
  logic [7:0]    loops_left, loops_left_nxt;

  logic [AW-1:0] rom_addr_nxt;
  logic [CW-1:0] lat_cnt, lat_cnt_nxt;
  logic          stop_pending, stop_pending_nxt;
  logic          done_sticky, done_sticky_nxt;
  logic          underrun, underrun_nxt;
  logic          done_nxt;

  logic ctrl_wr, ctrl_rd, start_cmd, stop_cmd;

  assign ctrl_wr   = wr_en && (reg_sel == 2'd0);
  assign ctrl_rd   = rd_en && (reg_sel == 2'd0);
  assign start_cmd = ctrl_wr && data_in[0];
  assign stop_cmd  = ctrl_wr && data_in[1];

  assign word_valid = (state == S_PLAY);
  assign mute       = (state == S_IDLE) || (state == S_PRIME);
  assign playing    = (state != S_IDLE);

  // register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_addr_r   <= '0;
      end_addr_r     <= '0;
      loop_cnt_r     <= '0;
      loop_forever_r <= 1'b0;
    end else if (wr_en) begin
      case (reg_sel)
        2'd0: loop_forever_r <= data_in[2];
        2'd1: start_addr_r   <= data_in[AW-1:0];
        2'd2: end_addr_r     <= data_in[AW-1:0];
        default: loop_cnt_r  <= data_in;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
    end else if (rd_en) begin
      case (reg_sel)
        2'd0: data_out <= {4'b0, underrun, done_sticky, loop_forever_r, playing};
        2'd1: data_out <= 8'(start_addr_r);
        2'd2: data_out <= 8'(end_addr_r);
        default: data_out <= loop_cnt_r;
      endcase
    end
  end

  // sequencer state and working registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      rom_addr     <= '0;
      lat_cnt      <= '0;
      w_start      <= '0;
      w_end        <= '0;
      w_forever    <= 1'b0;
      loops_left   <= '0;
      stop_pending <= 1'b0;
      done_sticky  <= 1'b0;
      underrun     <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      rom_addr     <= rom_addr_nxt;
      lat_cnt      <= lat_cnt_nxt;
      w_start      <= w_start_nxt;
      w_end        <= w_end_nxt;
      w_forever    <= w_forever_nxt;
      loops_left   <= loops_left_nxt;
      stop_pending <= stop_pending_nxt;
      done_sticky  <= done_sticky_nxt;
      underrun     <= underrun_nxt;
      done         <= done_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    rom_addr_nxt     = rom_addr;
    lat_cnt_nxt      = lat_cnt;
    w_start_nxt      = w_start;
    w_end_nxt        = w_end;
    w_forever_nxt    = w_forever;
    loops_left_nxt   = loops_left;
    done_nxt         = 1'b0;
    stop_pending_nxt = stop_pending || (stop_cmd && (state != S_IDLE));
    // a status read clears the sticky bits; a same-cycle new event wins below
    done_sticky_nxt  = done_sticky && !ctrl_rd;
    underrun_nxt     = underrun && !ctrl_rd;

    case (state)
      S_IDLE: begin
        if (start_cmd && !stop_cmd) begin
          state_nxt      = S_PRIME;
          rom_addr_nxt   = start_addr_r;
          w_start_nxt    = start_addr_r;
          w_end_nxt      = end_addr_r;
          // loop_forever comes from the same write that carries start
          w_forever_nxt  = data_in[2];
          loops_left_nxt = (loop_cnt_r == 8'd0) ? 8'd1 : loop_cnt_r;
          // one extra cycle beyond ROM latency before the first word
          lat_cnt_nxt    = CW'(ROM_LAT);
        end
      end

      S_PRIME: begin
        if (word_req) underrun_nxt = 1'b1;
        if (stop_cmd) begin
          state_nxt = S_IDLE;
        end else if (lat_cnt == '0) begin
          state_nxt = S_PLAY;
        end else begin
          lat_cnt_nxt = lat_cnt - CW'(1);
        end
      end

      S_PLAY: begin
        if (word_req) begin
          if (stop_pending) begin
            state_nxt = S_IDLE;
          end else if (rom_addr != w_end) begin
            rom_addr_nxt = rom_addr + AW'(1);
            lat_cnt_nxt  = CW'(ROM_LAT - 1);
            state_nxt    = S_FETCH;
          end else if (w_forever || (loops_left > 8'd1)) begin
            if (!w_forever) loops_left_nxt = loops_left - 8'd1;
            rom_addr_nxt = w_start;
            lat_cnt_nxt  = CW'(ROM_LAT - 1);
            state_nxt    = S_FETCH;
          end else begin
            state_nxt       = S_IDLE;
            done_nxt        = 1'b1;
            done_sticky_nxt = 1'b1;
          end
        end
      end

      S_FETCH: begin
        if (word_req) underrun_nxt = 1'b1;
        if (lat_cnt == '0) begin
          state_nxt = S_PLAY;
        end else begin
          lat_cnt_nxt = lat_cnt - CW'(1);
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    if (state_nxt == S_IDLE) stop_pending_nxt = 1'b0;
  end

endmodule
